accel_spi_ctrl: RTL

ACCEL_SPI_CTRL -- requirements
Module: accel_spi_ctrl

---
 rtl/accel_spi_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/accel_spi_ctrl.sv
// SPI-mode-0 slave bridging an accelerometer-style register protocol onto a register bus.
// Optional macro ACCEL_SPI_AUTOINC_EN: address auto-increment on multi-byte (MS) bursts.
module accel_spi_ctrl #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sck_i,
    input  logic              csn_i,
    input  logic              sdi_i,
    output logic              sdo_o,
    output logic              sdo_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic              reg_we_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StCmd, StFetch, StData} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, csn_sync_q, csn_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d, settle_q, settle_d;
    logic                   sck_prev_q, sck_prev_d, csn_prev_q, csn_prev_d;
    logic                   armed_q, armed_d;
    logic                   sck_s, csn_s, sdi_s, sck_rise, sck_fall, csn_fall, csn_rise;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d, rx_shift;
    logic [ADDR_W-1:0]      addr_q, addr_d, addr_step;
    logic                   rw_q, rw_d, sdo_q, sdo_d, oe_q, oe_d;
    logic                   we_q, we_d, re_q, re_d, fetch_wait_q, fetch_wait_d;

`ifdef ACCEL_SPI_AUTOINC_EN
    logic ms_q, ms_d;
    assign addr_step = ADDR_W'(ms_q);
`else
    assign addr_step = '0;
`endif

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    // A master may hold csn low across reset; only accept a fall once csn was seen high.
    assign csn_fall = ~csn_s & csn_prev_q & armed_q;
    assign csn_rise = csn_s & ~csn_prev_q;
    assign rx_shift = {rx_q[6:0], sdi_s};

    always_comb begin
        sck_sync_d = (sck_sync_q << 1) | SYNC_STAGES'(sck_i);
        csn_sync_d = (csn_sync_q << 1) | SYNC_STAGES'(csn_i);
        sdi_sync_d = (sdi_sync_q << 1) | SYNC_STAGES'(sdi_i);
        settle_d   = (settle_q << 1) | SYNC_STAGES'(1'b1);
        sck_prev_d = sck_s;
        csn_prev_d = csn_s;
        armed_d    = armed_q | (settle_q[SYNC_STAGES-1] & csn_s);
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        sdo_d        = sdo_q;
        oe_d         = oe_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        fetch_wait_d = fetch_wait_q;
`ifdef ACCEL_SPI_AUTOINC_EN
        ms_d         = ms_q;
`endif
        // Writes advance the address the cycle after the strobe so the strobe sees the old one.
        if (we_q) begin
            addr_d = addr_q + addr_step;
        end

        unique case (state_q)
            StIdle: begin
                if (csn_fall) begin
                    state_d   = StCmd;
                    bit_cnt_d = 3'd0;
                end
            end
            StCmd: begin
                if (sck_rise) begin
                    rx_d      = rx_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rw_d   = rx_shift[7];
                        addr_d = rx_shift[ADDR_W-1:0];
`ifdef ACCEL_SPI_AUTOINC_EN
                        ms_d   = rx_shift[6];
`endif
                        if (rx_shift[7]) begin
                            state_d      = StFetch;
                            re_d         = 1'b1;
                            fetch_wait_d = 1'b0;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StFetch: begin
                // re_q is high in the first cycle; rdata is valid one cycle later.
                if (!fetch_wait_q) begin
                    fetch_wait_d = 1'b1;
                end else begin
                    fetch_wait_d = 1'b0;
                    tx_d         = reg_rdata_i;
                    state_d      = StData;
                end
            end
            StData: begin
                if (sck_rise) begin
                    rx_d      = rx_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (rw_q) begin
                            addr_d       = addr_q + addr_step;
                            re_d         = 1'b1;
                            fetch_wait_d = 1'b0;
                            state_d      = StFetch;
                        end else begin
                            we_d    = 1'b1;
                            wdata_d = rx_shift;
                        end
                    end
                end
                if (sck_fall && rw_q) begin
                    sdo_d = tx_q[7];
                    tx_d  = {tx_q[6:0], 1'b0};
                    oe_d  = 1'b1;
                end
            end
        endcase

        // Evaluated after the sck rise so a coincident final write bit still strobes.
        if (csn_rise && state_q != StIdle) begin
            state_d      = StIdle;
            oe_d         = 1'b0;
            sdo_d        = 1'b0;
            re_d         = 1'b0;
            fetch_wait_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sck_sync_q   <= '0;
            csn_sync_q   <= '1;
            sdi_sync_q   <= '0;
            settle_q     <= '0;
            sck_prev_q   <= 1'b0;
            csn_prev_q   <= 1'b1;
            armed_q      <= 1'b0;
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 8'h00;
            tx_q         <= 8'h00;
            wdata_q      <= 8'h00;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            sdo_q        <= 1'b0;
            oe_q         <= 1'b0;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            fetch_wait_q <= 1'b0;
`ifdef ACCEL_SPI_AUTOINC_EN
            ms_q         <= 1'b0;
`endif
        end else begin
            sck_sync_q   <= sck_sync_d;
            csn_sync_q   <= csn_sync_d;
            sdi_sync_q   <= sdi_sync_d;
            settle_q     <= settle_d;
            sck_prev_q   <= sck_prev_d;
            csn_prev_q   <= csn_prev_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            sdo_q        <= sdo_d;
            oe_q         <= oe_d;
            we_q         <= we_d;
            re_q         <= re_d;
            fetch_wait_q <= fetch_wait_d;
`ifdef ACCEL_SPI_AUTOINC_EN
            ms_q         <= ms_d;
`endif
        end
    end

    assign sdo_o       = sdo_q & oe_q;
    assign sdo_oe_o    = oe_q;
    assign reg_addr_o  = addr_q;
    assign reg_we_o    = we_q;
    assign reg_wdata_o = wdata_q;
    assign reg_re_o    = re_q;
    assign busy_o      = (state_q != StIdle);

endmodule
